// File: rtl/toy_bus_periph_regfile_slave_if.sv
// ToyBus peripheral request/ack channel: master drives requests, slave returns read acks.
interface toy_bus_periph_regfile_slave_if;
    logic        req_vld;
    logic        req_rdy;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_strb;
    logic        req_opcode;
    logic        ack_vld;
    logic        ack_rdy;
    logic [31:0] ack_data;

    modport master (
        output req_vld, req_addr, req_data, req_strb, req_opcode, ack_rdy,
        input  req_rdy, ack_vld, ack_data
    );

    modport slave (
        input  req_vld, req_addr, req_data, req_strb, req_opcode, ack_rdy,
        output req_rdy, ack_vld, ack_data
    );
endinterface

// File: rtl/toy_bus_periph_regfile_slave.sv
// ToyBus register-file responder: byte-strobed posted writes, reads acked after RD_LATENCY.
// Define TOY_BUS_REGFILE_WR_ACK_EN to make writes also return a (zero-data) ack.
module toy_bus_periph_regfile_slave #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned NUM_REGS   = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    toy_bus_periph_regfile_slave_if.slave in0,
    output logic [NUM_REGS*32-1:0]     reg_q,
    output logic                       err_sticky,
    input  logic                       err_clr
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e                     state_q, state_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic [31:0]                rdata_q, rdata_d;
    logic [NUM_REGS-1:0][31:0]  regs_q, regs_d;
    logic                       err_q, err_d;

    logic          req_acc;
    logic          hit;
    logic          resp_start;
    logic [AW-1:0] idx;
    logic          unused_addr_lo;

    assign req_acc        = in0.req_vld && (state_q == StIdle);
    assign hit            = (in0.req_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign idx            = in0.req_addr[AW+1:2];
    assign unused_addr_lo = ^in0.req_addr[1:0];

`ifdef TOY_BUS_REGFILE_WR_ACK_EN
    assign resp_start = req_acc;
`else
    assign resp_start = req_acc && !in0.req_opcode;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        regs_d  = regs_q;
        err_d   = err_q;

        // Clear first so a simultaneous miss re-sets the flag.
        if (err_clr) begin
            err_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (req_acc) begin
                    if (!hit) begin
                        err_d = 1'b1;
                    end
                    if (in0.req_opcode && hit) begin
                        for (int b = 0; b < 4; b++) begin
                            if (in0.req_strb[b]) begin
                                regs_d[idx][8*b +: 8] = in0.req_data[8*b +: 8];
                            end
                        end
                    end
                    rdata_d = (hit && !in0.req_opcode) ? regs_q[idx] : 32'h0;
                end
                if (resp_start) begin
                    if (RD_LATENCY == 1) begin
                        state_d = StAck;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 2'(RD_LATENCY - 2);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 2'd0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StAck: begin
                if (in0.ack_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            rdata_q <= 32'h0;
            regs_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            regs_q  <= regs_d;
            err_q   <= err_d;
        end
    end

    assign in0.req_rdy  = (state_q == StIdle);
    assign in0.ack_vld  = (state_q == StAck);
    assign in0.ack_data = (state_q == StAck) ? rdata_q : 32'h0;
    assign reg_q        = regs_q;
    assign err_sticky   = err_q;
endmodule

// File: tb/tb_toy_bus_periph_regfile_slave.sv
// Randomized bench for toy_bus_periph_regfile_slave against an array-based model,
// covering RD_LATENCY=1 and RD_LATENCY=3 instances through one shared driver.
module tb_toy_bus_periph_regfile_slave;
    localparam logic [31:0] Base  = 32'h0000_1000;
    localparam int unsigned NRegs = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic err_clr;
    logic sel;
    logic req_vld, req_op, ack_rdy;
    logic [31:0] req_addr, req_data;
    logic [3:0]  req_strb;

    always #5 clk = ~clk;

    toy_bus_periph_regfile_slave_if bus1 ();
    toy_bus_periph_regfile_slave_if bus3 ();

    logic [NRegs*32-1:0] reg1, reg3;
    logic err1, err3;

    toy_bus_periph_regfile_slave #(
        .BASE_ADDR (Base),
        .NUM_REGS  (NRegs),
        .RD_LATENCY(1)
    ) u_dut_l1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (bus1),
        .reg_q     (reg1),
        .err_sticky(err1),
        .err_clr   (err_clr)
    );

    toy_bus_periph_regfile_slave #(
        .BASE_ADDR (Base),
        .NUM_REGS  (NRegs),
        .RD_LATENCY(3)
    ) u_dut_l3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in0       (bus3),
        .reg_q     (reg3),
        .err_sticky(err3),
        .err_clr   (err_clr)
    );

    // Route the single driver to the selected instance; the other sits idle.
    always_comb begin
        bus1.req_vld    = req_vld && !sel;
        bus3.req_vld    = req_vld && sel;
        bus1.req_addr   = req_addr;
        bus3.req_addr   = req_addr;
        bus1.req_data   = req_data;
        bus3.req_data   = req_data;
        bus1.req_strb   = req_strb;
        bus3.req_strb   = req_strb;
        bus1.req_opcode = req_op;
        bus3.req_opcode = req_op;
        bus1.ack_rdy    = sel ? 1'b1 : ack_rdy;
        bus3.ack_rdy    = sel ? ack_rdy : 1'b1;
    end

    logic        o_rdy, o_vld, o_err;
    logic [31:0] o_data;
    logic [NRegs*32-1:0] o_reg;
    assign o_rdy  = sel ? bus3.req_rdy  : bus1.req_rdy;
    assign o_vld  = sel ? bus3.ack_vld  : bus1.ack_vld;
    assign o_data = sel ? bus3.ack_data : bus1.ack_data;
    assign o_reg  = sel ? reg3 : reg1;
    assign o_err  = sel ? err3 : err1;

    logic [31:0] m_regs [2][NRegs];
    logic        m_err  [2];
    int n_checks = 0;
    int n_pass   = 0;

    function automatic int cur_lat();
        return sel ? 3 : 1;
    endfunction

    function automatic bit in_window(logic [31:0] a);
        return (a >= Base) && (a < Base + NRegs * 4);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic reset_models();
        for (int s = 0; s < 2; s++) begin
            m_err[s] = 1'b0;
            for (int i = 0; i < int'(NRegs); i++) m_regs[s][i] = 32'h0;
        end
    endtask

    task automatic check_model(input string tag);
        for (int i = 0; i < int'(NRegs); i++) begin
            check_eq($sformatf("%s reg%0d", tag, i), o_reg[32*i +: 32], m_regs[sel][i]);
        end
        check_eq($sformatf("%s err", tag), 32'(o_err), 32'(m_err[sel]));
    endtask

    // Presents one request and returns just after the accepting edge.
    task automatic accept_req(input logic op, input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic clr, input logic rdy_after,
                              output logic [31:0] exp_ack);
        int s;
        int idx;
        @(negedge clk);
        req_vld  = 1'b1;
        req_op   = op;
        req_addr = addr;
        req_data = data;
        req_strb = strb;
        err_clr  = clr;
        ack_rdy  = rdy_after;
        check_eq("req_rdy_idle", 32'(o_rdy), 32'd1);
        @(posedge clk);
        #1;
        req_vld = 1'b0;
        err_clr = 1'b0;
        s = sel ? 1 : 0;
        exp_ack = 32'h0;
        if (clr) begin
            m_err[0] = 1'b0;
            m_err[1] = 1'b0;
        end
        if (!in_window(addr)) begin
            m_err[s] = 1'b1;
        end else begin
            idx = int'((addr - Base) >> 2);
            if (op) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) m_regs[s][idx][8*b +: 8] = data[8*b +: 8];
                end
            end else begin
                exp_ack = m_regs[s][idx];
            end
        end
    endtask

    // Entered just after the accepting edge; ends just after the ack handshake.
    task automatic wait_ack(input logic [31:0] exp, input int hold);
        for (int k = 0; k < cur_lat() - 1; k++) begin
            check_eq("ack_vld_early", 32'(o_vld), 32'd0);
            check_eq("ack_data_idle", o_data, 32'h0);
            check_eq("req_rdy_busy", 32'(o_rdy), 32'd0);
            @(posedge clk);
            #1;
        end
        check_eq("ack_vld", 32'(o_vld), 32'd1);
        check_eq("ack_data", o_data, exp);
        check_eq("req_rdy_ack", 32'(o_rdy), 32'd0);
        for (int k = 0; k < hold; k++) begin
            if (k == 0) begin
                req_vld  = 1'b1;
                req_op   = 1'b1;
                req_addr = Base;
                req_data = 32'hDEAD_BEEF;
                req_strb = 4'hF;
            end
            @(posedge clk);
            #1;
            check_eq("ack_hold_vld", 32'(o_vld), 32'd1);
            check_eq("ack_hold_data", o_data, exp);
            check_eq("req_rdy_stall", 32'(o_rdy), 32'd0);
        end
        req_vld = 1'b0;
        ack_rdy = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ack_drop", 32'(o_vld), 32'd0);
        check_eq("req_rdy_back", 32'(o_rdy), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic clr);
        logic [31:0] unused_exp;
        accept_req(1'b1, addr, data, strb, clr, 1'b1, unused_exp);
`ifdef TOY_BUS_REGFILE_WR_ACK_EN
        wait_ack(32'h0, 0);
`else
        check_eq("wr_no_ack", 32'(o_vld), 32'd0);
        check_eq("wr_no_stall", 32'(o_rdy), 32'd1);
`endif
    endtask

    task automatic do_read(input logic [31:0] addr, input int hold, input logic clr);
        logic [31:0] exp;
        accept_req(1'b0, addr, $urandom, 4'($urandom), clr, hold == 0, exp);
        wait_ack(exp, hold);
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " rdy"}, 32'(o_rdy), 32'd1);
        check_eq({tag, " vld"}, 32'(o_vld), 32'd0);
        check_eq({tag, " data"}, o_data, 32'h0);
        check_model(tag);
    endtask

    initial begin
        logic [31:0] addr;
        logic [31:0] unused_rd;
        sel = 1'b0; req_vld = 1'b0; req_op = 1'b0; req_addr = 32'h0; req_data = 32'h0;
        req_strb = 4'h0; ack_rdy = 1'b1; err_clr = 1'b0; rst_n = 1'b0;
        reset_models();
        #12;
        check_idle("reset l1");
        sel = 1'b1;
        #1;
        check_idle("reset l3");
        sel = 1'b0;
        #9 rst_n = 1'b1;

        do_write(32'h1008, 32'hA5A5_1234, 4'hF, 1'b0);
        do_read(32'h1008, 0, 1'b0);
        check_eq("t1 reg2", o_reg[95:64], 32'hA5A5_1234);

        do_write(32'h1004, 32'hFFFF_FFFF, 4'b0101, 1'b0);
        do_read(32'h1004, 0, 1'b0);
        check_eq("t2 reg1", o_reg[63:32], 32'h00FF_00FF);

        do_read(32'h2000, 0, 1'b0);
        check_eq("t3 err set", 32'(o_err), 32'd1);
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        m_err[0] = 1'b0;
        m_err[1] = 1'b0;
        check_eq("t3 err clr", 32'(o_err), 32'd0);
        do_read(32'h2000, 0, 1'b1);
        check_eq("t3 set wins", 32'(o_err), 32'd1);

        do_read(32'h1008, 5, 1'b0);
        check_model("t4");

        sel = 1'b1;
        do_write(32'h101C, 32'h1234_5678, 4'hF, 1'b0);
        do_read(32'h101C, 2, 1'b0);
        check_model("t5");

        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            for (int n = 0; n < 40; n++) begin
                if ($urandom_range(0, 3) != 0)
                    addr = Base + 4 * $urandom_range(0, NRegs - 1) + $urandom_range(0, 3);
                else if ($urandom_range(0, 1) == 1)
                    addr = Base + NRegs * 4 + 4 * $urandom_range(0, 15);
                else
                    addr = Base - 4 - 4 * $urandom_range(0, 15);
                if ($urandom_range(0, 1) == 1)
                    do_write(addr, $urandom, 4'($urandom), $urandom_range(0, 7) == 0);
                else
                    do_read(addr, $urandom_range(0, 3), $urandom_range(0, 7) == 0);
                check_model("rand");
            end
        end

        // Reset while the latency-3 instance is presenting an ack.
        sel = 1'b1;
        do_write(32'h1010, 32'hCAFE_F00D, 4'hF, 1'b0);
        accept_req(1'b0, 32'h1010, 32'h0, 4'h0, 1'b0, 1'b0, unused_rd);
        repeat (cur_lat() - 1) begin
            @(posedge clk);
            #1;
        end
        check_eq("t6 ack before rst", 32'(o_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        reset_models();
        check_eq("t6 vld in rst", 32'(o_vld), 32'd0);
        check_model("t6 rst");
        #1 rst_n = 1'b1;
        ack_rdy = 1'b1;
        #1;
        check_idle("t6 after rst");
        do_write(32'h1000, 32'h0BAD_F00D, 4'b1100, 1'b0);
        do_read(32'h1000, 1, 1'b0);
        check_model("t6 post");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
